// File: rtl/cpu_pkg.sv
// Shared RV32M definitions for the EX-stage multiply/divide unit.
// Holds funct3 op codes and the unit's FSM state encoding.
package cpu_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    FIXUP,
    DONE
  } muldiv_state_e;

endpackage

// File: rtl/div_radix2_core.sv
// Unsigned restoring radix-2 divider: one quotient bit per step, MSB first.
// After load, XLEN steps leave quotient/remainder of the loaded magnitudes.
module div_radix2_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            last
);

  localparam int CW = $clog2(XLEN);

  logic [XLEN-1:0] rem_q, quo_q, dvsr_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN:0]   shifted, diff;

  // Partial remainder stays below the divisor, so XLEN+1 bits hold the trial difference.
  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign diff    = shifted - {1'b0, dvsr_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvsr_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      rem_q  <= '0;
      quo_q  <= dividend;
      dvsr_q <= divisor;
      cnt_q  <= CW'(XLEN - 1);
    end else if (step) begin
      rem_q  <= diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      quo_q  <= {quo_q[XLEN-2:0], ~diff[XLEN]};
      cnt_q  <= cnt_q - 1'b1;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign last      = (cnt_q == '0);

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage RV32M multiply/divide unit: 2-cycle multiply, 34-cycle iterative divide.
// Holds the pipeline via stall while an op is in flight; flush kills the op silently.
module ex_muldiv_unit
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      done_rd
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e state_q, state_d;

  logic [2:0]      op_f3_q;
  logic [4:0]      op_rd_q;
  logic [XLEN-1:0] op_a_q, op_b_q;
  logic            neg_q_q, neg_r_q;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      done_rd_q, rd_d;

  logic            can_issue, accept, special;
  logic            div_zero, div_ovf, div_signed, a_neg, b_neg;
  logic [XLEN-1:0] abs_a, abs_b, special_res;
  logic            div_load, div_step, div_last;
  logic [XLEN-1:0] quotient, remainder, q_fix, r_fix;

  logic                   a_sgn, b_sgn;
  logic signed [2*XLEN+1:0] ma, mb, prod;
  logic [XLEN-1:0]        mul_res;

  assign can_issue  = (state_q == IDLE) || (state_q == DONE);
  assign accept     = start && !flush && can_issue;

  assign div_signed = !funct3[0];
  assign div_zero   = (rs2_data == '0);
  assign div_ovf    = div_signed && (rs1_data == MIN_NEG) && (rs2_data == '1);
  assign special    = funct3[2] && (div_zero || div_ovf);

  assign a_neg = div_signed && rs1_data[XLEN-1];
  assign b_neg = div_signed && rs2_data[XLEN-1];
  assign abs_a = a_neg ? -rs1_data : rs1_data;
  assign abs_b = b_neg ? -rs2_data : rs2_data;

  always_comb begin
    special_res = '0;
    if (div_zero)       special_res = funct3[1] ? rs1_data : '1;
    else if (!funct3[1]) special_res = MIN_NEG;
  end

  assign div_load = accept && funct3[2] && !special;
  assign div_step = (state_q == DIV) && !flush;

  div_radix2_core #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (div_load),
    .step      (div_step),
    .dividend  (abs_a),
    .divisor   (abs_b),
    .quotient  (quotient),
    .remainder (remainder),
    .last      (div_last)
  );

  // Extending to 2*XLEN+2 bits keeps the signed product exact for every operand mix.
  assign a_sgn   = (op_f3_q == F3_MULH) || (op_f3_q == F3_MULHSU);
  assign b_sgn   = (op_f3_q == F3_MULH);
  assign ma      = {{(XLEN+2){a_sgn & op_a_q[XLEN-1]}}, op_a_q};
  assign mb      = {{(XLEN+2){b_sgn & op_b_q[XLEN-1]}}, op_b_q};
  assign prod    = ma * mb;
  assign mul_res = (op_f3_q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  assign q_fix = neg_q_q ? -quotient : quotient;
  assign r_fix = neg_r_q ? -remainder : remainder;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) state_d = !funct3[2] ? MUL : (special ? DONE : DIV);
          else       state_d = IDLE;
        end
        MUL:     state_d = DONE;
        DIV:     if (div_last) state_d = FIXUP;
        FIXUP:   state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    result_d = result_q;
    rd_d     = done_rd_q;
    if (accept && special) begin
      result_d = special_res;
      rd_d     = rd;
    end else if (!flush && state_q == MUL) begin
      result_d = mul_res;
      rd_d     = op_rd_q;
    end else if (!flush && state_q == FIXUP) begin
      result_d = op_f3_q[1] ? r_fix : q_fix;
      rd_d     = op_rd_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_f3_q   <= '0;
      op_rd_q   <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      result_q  <= '0;
      done_rd_q <= '0;
    end else begin
      if (accept) begin
        op_f3_q <= funct3;
        op_rd_q <= rd;
        op_a_q  <= rs1_data;
        op_b_q  <= rs2_data;
        neg_q_q <= a_neg ^ b_neg;
        neg_r_q <= a_neg;
      end
      result_q  <= result_d;
      done_rd_q <= rd_d;
    end
  end

  assign busy    = (state_q == MUL) || (state_q == DIV) || (state_q == FIXUP);
  assign stall   = (accept && !special) || busy;
  assign done    = (state_q == DONE);
  assign result  = result_q;
  assign done_rd = done_rd_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: expected results queued at issue, popped on done.
module tb_ex_muldiv_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, flush = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rs1_data = '0, rs2_data = '0;
  logic [4:0]  rd = '0;
  logic        stall, busy, done;
  logic [31:0] result;
  logic [4:0]  done_rd;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0, failures = 0, done_cnt = 0, n_exp = 0;
  logic [31:0] prev_res;

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd(rd), .flush(flush),
    .stall(stall), .busy(busy), .done(done), .result(result), .done_rd(done_rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sp;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f3)
      3'b000: begin up = ua * ub; return up[31:0]; end
      3'b001: begin sp = sa * sb; return sp[63:32]; end
      3'b010: begin sp = sa * longint'(ub); return sp[63:32]; end
      3'b011: begin up = ua * ub; return up[63:32]; end
      3'b100: begin if (b == 0) return '1; sp = sa / sb; return sp[31:0]; end
      3'b101: begin if (b == 0) return '1; up = ua / ub; return up[31:0]; end
      3'b110: begin if (b == 0) return a; sp = sa % sb; return sp[31:0]; end
      default: begin if (b == 0) return a; up = ua % ub; return up[31:0]; end
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_result", result, mon_e.res);
        chk("sb_rd", {27'd0, done_rd}, {27'd0, mon_e.rd});
      end
    end
  end

  task automatic drv_edge();
    @(posedge clk);
    #1;
  endtask

  // Issues one op at the current drive point and waits (bounded) for its done pulse.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r, input int lat, input string tag);
    int cyc;
    bit got, bad;
    funct3 = f3; rs1_data = a; rs2_data = b; rd = r; start = 1'b1;
    exp_q.push_back({model(f3, a, b), r});
    n_exp++;
    @(negedge clk);
    chk({tag, "_stall0"}, {31'd0, stall}, (lat == 1) ? 32'd0 : 32'd1);
    cyc = 0; got = 0; bad = 0;
    while (!got && cyc < 60) begin
      drv_edge();
      start = 1'b0;
      cyc++;
      @(negedge clk);
      if (done) got = 1;
      else if (busy !== (lat > 1)) bad = 1;
    end
    chk({tag, "_lat"}, cyc, lat);
    chk({tag, "_busy"}, {31'd0, bad}, 32'd0);
    chk({tag, "_stall_done"}, {31'd0, stall}, 32'd0);
    drv_edge();
  endtask

  initial begin
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_rd", {27'd0, done_rd}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    drv_edge();
    rst_n = 1'b1;
    drv_edge();

    run_op(F3_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 2, "mul");
    chk("mul_direct", result, 32'hFFFF_FFEB);
    chk("mul_rd_held", {27'd0, done_rd}, 32'd5);
    run_op(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 2, "mulhu");
    chk("mulhu_direct", result, 32'hFFFF_FFFE);
    run_op(F3_MULH, 32'h8000_0000, 32'h8000_0000, 5'd7, 2, "mulh");
    chk("mulh_direct", result, 32'h4000_0000);
    run_op(F3_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 5'd8, 2, "mulhsu");
    run_op(F3_MULHSU, 32'h1234_5678, 32'hF000_0000, 5'd9, 2, "mulhsu2");

    run_op(F3_DIV, 32'hFFFF_FFF9, 32'd2, 5'd10, 34, "div");
    chk("div_direct", result, 32'hFFFF_FFFD);
    run_op(F3_REM, 32'hFFFF_FFF9, 32'd2, 5'd11, 34, "rem");
    chk("rem_direct", result, 32'hFFFF_FFFF);
    run_op(F3_DIVU, 32'd100, 32'd7, 5'd12, 34, "divu");
    run_op(F3_REMU, 32'hF000_0001, 32'd9, 5'd13, 34, "remu");
    run_op(F3_DIV, 32'd7, 32'hFFFF_FFFE, 5'd14, 34, "div_negb");
    run_op(F3_REM, 32'd7, 32'hFFFF_FFFE, 5'd15, 34, "rem_negb");

    run_op(F3_DIVU, 32'd5, 32'd0, 5'd16, 1, "divu_z");
    chk("divu_z_direct", result, 32'hFFFF_FFFF);
    run_op(F3_REMU, 32'd5, 32'd0, 5'd17, 1, "remu_z");
    chk("remu_z_direct", result, 32'd5);
    run_op(F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 1, "div_ovf");
    chk("div_ovf_direct", result, 32'h8000_0000);
    run_op(F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 1, "rem_ovf");
    run_op(F3_DIV, 32'hFFFF_FF00, 32'd0, 5'd20, 1, "div_z");

    // Flush at cycle 10 of a DIV: nothing queued, so any done would be flagged.
    prev_res = result;
    funct3 = F3_DIV; rs1_data = 32'd1000; rs2_data = 32'd3; rd = 5'd21; start = 1'b1;
    @(negedge clk);
    drv_edge();
    start = 1'b0;
    for (int i = 1; i < 10; i++) drv_edge();
    flush = 1'b1;
    @(negedge clk);
    chk("flush_busy_c10", {31'd0, busy}, 32'd1);
    drv_edge();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_stall", {31'd0, stall}, 32'd0);
    chk("flush_done", {31'd0, done}, 32'd0);
    chk("flush_result", result, prev_res);
    for (int i = 0; i < 40; i++) drv_edge();
    run_op(F3_MUL, 32'hFFFF_FFFF, 32'd3, 5'd22, 2, "mul_after_flush");

    // start held with changing operands while busy must not disturb the divide.
    begin
      int cyc;
      bit got;
      funct3 = F3_DIVU; rs1_data = 32'd100; rs2_data = 32'd7; rd = 5'd3; start = 1'b1;
      exp_q.push_back({32'd14, 5'd3});
      n_exp++;
      @(negedge clk);
      cyc = 0; got = 0;
      while (!got && cyc < 60) begin
        drv_edge();
        cyc++;
        if (cyc <= 20) begin
          funct3 = F3_MUL; rs1_data = $urandom; rs2_data = $urandom; rd = 5'(cyc);
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        if (done) got = 1;
      end
      chk("held_start_lat", cyc, 32'd34);
      drv_edge();
    end

    // Back-to-back: second op accepted in the first op's DONE cycle.
    funct3 = F3_MUL; rs1_data = 32'd3; rs2_data = 32'd5; rd = 5'd1; start = 1'b1;
    exp_q.push_back({32'd15, 5'd1});
    n_exp++;
    @(negedge clk);
    drv_edge();
    start = 1'b0;
    drv_edge();
    funct3 = F3_MULHU; rs1_data = 32'h8000_0000; rs2_data = 32'd4; rd = 5'd2; start = 1'b1;
    exp_q.push_back({32'd2, 5'd2});
    n_exp++;
    @(negedge clk);
    chk("b2b_done1", {31'd0, done}, 32'd1);
    chk("b2b_stall", {31'd0, stall}, 32'd1);
    drv_edge();
    start = 1'b0;
    @(negedge clk);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    chk("b2b_nodone", {31'd0, done}, 32'd0);
    drv_edge();
    @(negedge clk);
    chk("b2b_done2", {31'd0, done}, 32'd1);
    drv_edge();

    // Async reset in the middle of a divide.
    funct3 = F3_DIV; rs1_data = 32'd1000; rs2_data = 32'd3; rd = 5'd4; start = 1'b1;
    @(negedge clk);
    drv_edge();
    start = 1'b0;
    for (int i = 0; i < 4; i++) drv_edge();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_result", result, 32'd0);
    chk("mid_rst_rd", {27'd0, done_rd}, 32'd0);
    chk("mid_rst_stall", {31'd0, stall}, 32'd0);
    drv_edge();
    rst_n = 1'b1;
    drv_edge();
    run_op(F3_REMU, 32'd1000, 32'd3, 5'd23, 34, "remu_after_rst");

    chk("sb_empty", exp_q.size(), 32'd0);
    chk("done_count", done_cnt, n_exp);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
